// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Converts byte addresses to word indices and models a fixed wait-state access.
module dmem_arbiter #(
  parameter int BASE_ADDR   = 1024,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd_i,
  input  logic              p0_wr_i,
  input  logic [31:0]       p0_addr_i,
  input  logic [31:0]       p0_wdata_i,
  output logic [31:0]       p0_rdata_o,
  output logic              p0_ready_o,
  output logic              p0_err_o,
  input  logic              p1_rd_i,
  input  logic              p1_wr_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_wdata_i,
  output logic [31:0]       p1_rdata_o,
  output logic              p1_ready_o,
  output logic              p1_err_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a requester holds pN_rd/pN_wr (with stable addr/wdata) until
  // the single-cycle pN_ready pulse, and drops or changes it at the edge
  // that ends that cycle; a request still held afterwards is a new request.

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               prio_q;
  logic               port_q;
  logic               wr_q;
  logic               err_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        p0_rdata_q, p1_rdata_q;

  logic               req0, req1, gnt_any, gnt_port;
  logic               sel_wr;
  logic [31:0]        sel_addr, sel_wdata;
  logic [31:0]        offset, word;
  logic               range_err;
  logic [ADDR_W-1:0]  idx_d;

  // Grant selection and address check for the request being arbitrated.
  always_comb begin
    req0      = p0_rd_i | p0_wr_i;
    req1      = p1_rd_i | p1_wr_i;
    gnt_any   = req0 | req1;
    gnt_port  = (req0 & req1) ? prio_q : req1;
    sel_wr    = gnt_port ? p1_wr_i    : p0_wr_i;
    sel_addr  = gnt_port ? p1_addr_i  : p0_addr_i;
    sel_wdata = gnt_port ? p1_wdata_i : p0_wdata_i;
    offset    = sel_addr - 32'(BASE_ADDR);
    word      = offset >> 2;
    range_err = (sel_addr < 32'(BASE_ADDR)) || ((word >> ADDR_W) != 32'd0);
    idx_d     = word[ADDR_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt_any) state_d = range_err ? S_DONE : S_ACCESS;
      S_ACCESS: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p0_ready_o  = (state_q == S_DONE) && (port_q == 1'b0);
    p1_ready_o  = (state_q == S_DONE) && (port_q == 1'b1);
    p0_err_o    = p0_ready_o & err_q;
    p1_err_o    = p1_ready_o & err_q;
    mem_we_o    = (state_q == S_ACCESS) && (cnt_q == '0) && wr_q;
    mem_addr_o  = idx_q;
    mem_wdata_o = wdata_q;
    p0_rdata_o  = p0_rdata_q;
    p1_rdata_o  = p1_rdata_q;
    dbg_state_o = state_q;
  end

  // Transfer latches; rdata registers update only when a transfer completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= 1'b0;
      port_q     <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && gnt_any) begin
        port_q  <= gnt_port;
        wr_q    <= sel_wr;
        err_q   <= range_err;
        idx_q   <= idx_d;
        wdata_q <= sel_wdata;
        cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
        prio_q  <= ~gnt_port;
        if (range_err) begin
          if (gnt_port) p1_rdata_q <= '0;
          else          p0_rdata_q <= '0;
        end
      end
      if (state_q == S_ACCESS) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end else if (port_q) begin
          p1_rdata_q <= wr_q ? 32'd0 : mem_rdata_i;
        end else begin
          p0_rdata_q <= wr_q ? 32'd0 : mem_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases plus two randomized requesters,
// checked each cycle against a transaction-timeline model of the arbiter.
module tb_dmem_arbiter;

  localparam int BASE = 1024;
  localparam int AW   = 16;
  localparam int W    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0, d0 = '0, d1 = '0;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_ready, p1_ready, p0_err, p1_err;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_mem [64];

  dmem_arbiter #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_i(rd0), .p0_wr_i(wr0), .p0_addr_i(a0), .p0_wdata_i(d0),
    .p0_rdata_o(p0_rdata), .p0_ready_o(p0_ready), .p0_err_o(p0_err),
    .p1_rd_i(rd1), .p1_wr_i(wr1), .p1_addr_i(a1), .p1_wdata_i(d1),
    .p1_rdata_o(p1_rdata), .p1_ready_o(p1_ready), .p1_err_o(p1_err),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 1) return 32'hDEADBEEF;
    if (i == 2) return 32'h0BADF00D;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  // Bench-side memory: combinational read, written on the clock edge.
  assign mem_rdata = tb_mem[mem_addr[5:0]];
  initial begin
    for (int i = 0; i < 64; i++) tb_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_we) tb_mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: one transfer at a time, each with known grant/access/ready cycles.
  initial begin : model
    logic [31:0] ref_mem [64];
    int cyc = 0, free_cyc = 0, prio = 0;
    bit pend = 0;
    int g_port = 0, g_idx = 0, acc_cyc = 0, rdy_cyc = 0;
    bit g_wr = 0, g_err = 0;
    logic [31:0] g_wdata = '0, g_rdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend = 0; prio = 0; free_cyc = 0;
        chk("rst_p0_ready", {31'd0, p0_ready}, 32'd0);
        chk("rst_p1_ready", {31'd0, p1_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
      end else begin
        bit e_r0, e_r1, e_acc;
        logic r0, r1;
        e_r0  = pend && cyc == rdy_cyc && g_port == 0;
        e_r1  = pend && cyc == rdy_cyc && g_port == 1;
        e_acc = pend && !g_err && cyc == acc_cyc;
        chk("p0_ready", {31'd0, p0_ready}, {31'd0, e_r0});
        chk("p1_ready", {31'd0, p1_ready}, {31'd0, e_r1});
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_acc && g_wr});
        if (e_acc) begin
          chk("mem_addr", 32'(mem_addr), 32'(g_idx));
          if (g_wr) begin
            chk("mem_wdata", mem_wdata, g_wdata);
            ref_mem[g_idx] = g_wdata;
          end
        end
        chk("p0_err", {31'd0, p0_err}, {31'd0, e_r0 && g_err});
        chk("p1_err", {31'd0, p1_err}, {31'd0, e_r1 && g_err});
        if (e_r0) chk("p0_rdata", p0_rdata, g_rdata);
        if (e_r1) chk("p1_rdata", p1_rdata, g_rdata);
        if (pend && cyc == rdy_cyc) begin
          pend = 0;
          free_cyc = cyc + 1;
        end
        r0 = rd0 | wr0;
        r1 = rd1 | wr1;
        if (!pend && cyc >= free_cyc && (r0 || r1)) begin
          longint addr;
          longint off;
          g_port  = (r0 && r1) ? prio : (r1 ? 1 : 0);
          prio    = 1 - g_port;
          g_wr    = g_port ? wr1 : wr0;
          addr    = longint'(g_port ? a1 : a0);
          g_wdata = g_port ? d1 : d0;
          off     = addr - BASE;
          g_err   = (addr < BASE) || ((off / 4) >= (64'd1 << AW));
          g_idx   = g_err ? 0 : int'(off / 4);
          g_rdata = (g_err || g_wr) ? 32'd0 : ref_mem[g_idx];
          acc_cyc = cyc + W;
          rdy_cyc = g_err ? cyc + 1 : cyc + W + 1;
          pend    = 1;
        end
      end
    end
  end

  task automatic set_req(input int n, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    if (n == 0) begin rd0 = rd; wr0 = wr; a0 = a; d0 = d; end
    else        begin rd1 = rd; wr1 = wr; a1 = a; d1 = d; end
  endtask

  // Call just after a rising edge; returns cycles from request to ready.
  task automatic do_req(input int n, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdat, output logic er);
    bit got = 0;
    set_req(n, rd, wr, a, d);
    lat = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (n == 0 ? p0_ready : p1_ready) got = 1;
      else lat++;
    end
    if (!got) begin
      errors++;
      $display("FAIL timeout port %0d: no ready within 100 cycles", n);
    end
    rdat = (n == 0) ? p0_rdata : p1_rdata;
    er   = (n == 0) ? p0_err : p1_err;
    @(posedge clk); #1;
    set_req(n, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rand_port(input int n, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int gap, op, k, lat;
      logic [31:0] addr, rdat;
      logic er;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      op = $urandom_range(1, 3);
      k  = $urandom_range(0, 9);
      if (k == 0)      addr = 32'($urandom_range(0, BASE - 1));
      else if (k == 1) addr = 32'(BASE + 4 * (1 << AW) + $urandom_range(0, 4096));
      else             addr = 32'(BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3));
      do_req(n, op[0], op[1], addr, $urandom, lat, rdat, er);
    end
  endtask

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    int l0a, l0b, l1;
    logic [31:0] r0a, r0b, r1v;
    logic e0a, e0b, e1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_idle_state", 32'(dbg_state), 32'd0);
    chk("reset_p0_rdata", p0_rdata, 32'd0);
    @(posedge clk); #1;

    // Simultaneous requests, then port 0 re-requests while port 1 waits.
    fork
      begin
        do_req(0, 1'b1, 1'b0, 32'd1028, 32'd0, l0a, r0a, e0a);
        do_req(0, 1'b1, 1'b0, 32'd1032, 32'd0, l0b, r0b, e0b);
      end
      do_req(1, 1'b1, 1'b0, 32'd1036, 32'd0, l1, r1v, e1);
    join
    chk("t3_p0_first_lat", 32'(l0a), 32'd4);
    chk("t3_p1_second_lat", 32'(l1), 32'd9);
    chk("t3_p0_third_lat", 32'(l0b), 32'd9);

    do_req(0, 1'b1, 1'b0, 32'd1028, 32'd0, l0a, r0a, e0a);
    chk("t1_lat", 32'(l0a), 32'd4);
    chk("t1_rdata", r0a, 32'hDEADBEEF);
    chk("t1_err", {31'd0, e0a}, 32'd0);

    do_req(1, 1'b0, 1'b1, 32'd1024, 32'h12345678, l1, r1v, e1);
    chk("t2_lat", 32'(l1), 32'd4);
    chk("t2_err", {31'd0, e1}, 32'd0);
    chk("t2_mem0", tb_mem[0], 32'h12345678);

    do_req(0, 1'b1, 1'b0, 32'd1000, 32'd0, l0a, r0a, e0a);
    chk("t4_lat", 32'(l0a), 32'd1);
    chk("t4_err", {31'd0, e0a}, 32'd1);

    do_req(0, 1'b0, 1'b1, 32'(BASE + 4 * (1 << AW)), 32'h55AA55AA, l0a, r0a, e0a);
    chk("t5_hi_lat", 32'(l0a), 32'd1);
    chk("t5_hi_err", {31'd0, e0a}, 32'd1);
    do_req(0, 1'b1, 1'b0, 32'd1031, 32'd0, l0a, r0a, e0a);
    chk("t5_align_lat", 32'(l0a), 32'd4);
    chk("t5_align_rdata", r0a, 32'hDEADBEEF);

    // Reset during the second access cycle of a write.
    set_req(1, 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t6_ready", {30'd0, p0_ready, p1_ready}, 32'd0);
    chk("t6_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1 set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("t6_mem2_kept", tb_mem[2], 32'h0BADF00D);
    #1;

    fork
      rand_port(0, 60);
      rand_port(1, 60);
    join
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
